// File: rtl/memory_pkg.sv
// Shared types for the memory stage: data-bus request/response, control
// bits carried down the pipe, and the E/M and M/W pipeline payloads.
// Helpers compute the byte-lane mask and alignment check for an access size.
package memory_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  // Access size encoding, log2 of the byte count.
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    msize_t          size;
    logic [7:0]      strobe;
    logic [63:0]     data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic   regWrite;
    logic   memRead;
    logic   memWrite;
    msize_t msize;
    logic   memUnsigned;
  } ctl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    ctl_t            ctl;
    logic [REGW-1:0] dst;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] srcb;
  } execute_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    ctl_t            ctl;
    logic [REGW-1:0] dst;
    logic [XLEN-1:0] result;
  } memory_data_t;

  // Byte lanes touched by an access of the given size starting at lane 0.
  function automatic logic [7:0] size_mask(input msize_t s);
    logic [7:0] m;
    case (s)
      MSIZE1:  m = 8'h01;
      MSIZE2:  m = 8'h03;
      MSIZE4:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] a, input msize_t s);
    logic r;
    case (s)
      MSIZE1:  r = 1'b0;
      MSIZE2:  r = a[0];
      MSIZE4:  r = |a[1:0];
      default: r = |a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_memalign.sv
// memalign: combinational lane steering between the pipeline and the 64-bit bus.
// Ports: addr_i/size_i/unsigned_i describe the access; wdata_i -> strobe_o/wdata_o
// for stores; rdata_i (raw bus word) -> rdata_o (extracted, extended load value).
module memalign
  import memory_pkg::*;
(
  input  logic [2:0]  addr_i,
  input  msize_t      size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  strobe_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  bit_ofs;
  logic [63:0] rshift;

  assign bit_ofs  = {addr_i, 3'b000};

  // Store side: move the low-order bytes up to the addressed lanes.
  assign strobe_o = size_mask(size_i) << addr_i;
  assign wdata_o  = wdata_i << bit_ofs;

  // Load side: bring the addressed lanes down to bit 0, then extend.
  assign rshift   = rdata_i >> bit_ofs;

  always_comb begin
    rdata_o = rshift;
    case (size_i)
      MSIZE1: rdata_o = unsigned_i ? {56'h0, rshift[7:0]}
                                   : {{56{rshift[7]}}, rshift[7:0]};
      MSIZE2: rdata_o = unsigned_i ? {48'h0, rshift[15:0]}
                                   : {{48{rshift[15]}}, rshift[15:0]};
      MSIZE4: rdata_o = unsigned_i ? {32'h0, rshift[31:0]}
                                   : {{32{rshift[31]}}, rshift[31:0]};
      default: rdata_o = rshift;
    endcase
  end

endmodule

// File: rtl/memory.sv
// memory: pipeline memory stage; issues loads/stores on the data bus and
// produces the writeback payload. Ports: clk/reset, dataE (from E/M), stall_in,
// dreq/dresp (data bus), dataM (to writeback), stallM (waiting on bus), misalign.
module memory
  import memory_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          stall_in,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM,
  output logic          misalign
);

  // IDLE issues, WAIT has a request outstanding, DONE holds a captured
  // response until the rest of the pipeline lets this instruction go.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] rdata_q;

  logic        mem_rw;
  logic        memop;
  logic [7:0]  st_strobe;
  logic [63:0] st_data;
  logic [63:0] ld_data;

  assign mem_rw   = dataE.ctl.memRead | dataE.ctl.memWrite;
  assign misalign = dataE.valid & mem_rw &
                    is_misaligned(dataE.alu_out[2:0], dataE.ctl.msize);
  assign memop    = dataE.valid & mem_rw & ~misalign;

  memalign u_align (
    .addr_i     (dataE.alu_out[2:0]),
    .size_i     (dataE.ctl.msize),
    .unsigned_i (dataE.ctl.memUnsigned),
    .wdata_i    (dataE.srcb),
    .rdata_i    (dresp.data),
    .strobe_o   (st_strobe),
    .wdata_o    (st_data),
    .rdata_o    (ld_data)
  );

  // Sequencing of the bus transaction. The captured value is the already
  // extended load result, so DONE needs nothing from the bus.
  // A data_ok seen in IDLE without a live memop is a slave error and is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (memop) begin
            if (dresp.data_ok) begin
              rdata_q <= ld_data;
              if (stall_in) state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dresp.data_ok) begin
            rdata_q <= ld_data;
            state_q <= stall_in ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (!stall_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The request is combinational from dataE so it goes out in the same cycle
  // the instruction arrives. Reset gates valid so an in-flight request is
  // withdrawn at once rather than at the next edge.
  always_comb begin
    dreq.valid  = ~reset & (((state_q == S_IDLE) & memop) | (state_q == S_WAIT));
    dreq.addr   = dataE.alu_out;
    dreq.size   = dataE.ctl.msize;
    dreq.strobe = dataE.ctl.memWrite ? st_strobe : 8'h00;
    dreq.data   = st_data;
  end

  // A response arriving this cycle releases the stall in the same cycle.
  assign stallM = ~reset & memop & (state_q != S_DONE) & ~dresp.data_ok;

  always_comb begin
    dataM.valid = dataE.valid & ~stallM;
    dataM.pc    = dataE.pc;
    dataM.ctl   = dataE.ctl;
    dataM.dst   = dataE.dst;
    if (memop & dataE.ctl.memRead)
      dataM.result = (state_q == S_DONE) ? rdata_q : ld_data;
    else
      dataM.result = dataE.alu_out;
  end

endmodule
